trap_hazard_controller: RTL and testbench

Parameterised pipeline hazard and trap controller, the successor to the current combinational hazard unit. Takes per-stage exception requests, branch redirects, a global memory-busy stall and load-use operand checks. Drives per-stage stall/flush vectors and a registered trap record (cause, PC, tval) for the CSR/trap-vector logic. Adds a trap FSM, multi-cycle load-use stalls and N-operand hazard checks.

---
 rtl/trap_hazard_controller.sv | 169 ++++++++++++++++
 tb/tb_trap_hazard_controller.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_hazard_controller.sv
// Pipeline hazard and trap controller.
// It watches per-stage exception requests, branch redirects, a global memory-busy freeze and
// load-use operand conflicts. It drives per-stage stall/flush vectors and a registered trap
// record (cause, PC, tval) that the CSR/trap-vector logic consumes.
module trap_hazard_controller #(
    parameter int unsigned STAGES          = 4,
    parameter int unsigned XLEN            = 32,
    parameter int unsigned CAUSE_W         = 4,
    parameter int unsigned LOAD_USE_CYCLES = 1,
    parameter int unsigned HAZARD_REGS     = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [STAGES-1:0]          excValid,
    input  logic [STAGES*CAUSE_W-1:0]  excCause,
    input  logic [STAGES*XLEN-1:0]     excPc,
    input  logic [STAGES*XLEN-1:0]     excTval,
    input  logic                       branchValid,
    input  logic                       memBusy,
    input  logic                       useValid,
    input  logic [HAZARD_REGS*5-1:0]   useRegs,
    input  logic                       loadValid,
    input  logic [4:0]                 loadRd,
    output logic [STAGES-1:0]          stall,
    output logic [STAGES-1:0]          flush,
    output logic                       trapValid,
    output logic [CAUSE_W-1:0]         trapCause,
    output logic [XLEN-1:0]            trapPc,
    output logic [XLEN-1:0]            trapTval,
    output logic                       loadUseStall
);

    localparam int unsigned IdxW = (STAGES > 1) ? $clog2(STAGES) : 1;
    // 3 bits covers the full 1..7 bubble range.
    localparam int unsigned CntW = 3;
    localparam logic [CntW-1:0] CntReload = CntW'(LOAD_USE_CYCLES - 1);

    typedef enum logic [0:0] {
        StIdle,
        StTrap
    } state_e;

    state_e              r_state;
    logic [CntW-1:0]     r_count;
    logic [CAUSE_W-1:0]  r_trap_cause;
    logic [XLEN-1:0]     r_trap_pc;
    logic [XLEN-1:0]     r_trap_tval;

    state_e              w_state_next;
    logic [CntW-1:0]     w_count_next;
    logic                w_latch;

    logic                w_exc_any;
    logic [IdxW-1:0]     w_exc_idx;
    logic [STAGES-1:0]   w_exc_mask;
    logic [CAUSE_W-1:0]  w_sel_cause;
    logic [XLEN-1:0]     w_sel_pc;
    logic [XLEN-1:0]     w_sel_tval;

    logic                w_reg_hit;
    logic                w_hazard;

    // Pick the oldest excepting instruction (highest stage index) and its trap record.
    always_comb begin
        w_exc_any   = |excValid;
        w_exc_idx   = '0;
        w_sel_cause = '0;
        w_sel_pc    = '0;
        w_sel_tval  = '0;
        for (int i = 0; i < int'(STAGES); i++) begin
            if (excValid[i]) begin
                w_exc_idx   = IdxW'(i);
                w_sel_cause = excCause[i*CAUSE_W +: CAUSE_W];
                w_sel_pc    = excPc[i*XLEN +: XLEN];
                w_sel_tval  = excTval[i*XLEN +: XLEN];
            end
        end
    end

    // Flush mask covering the winning stage and every younger stage below it.
    always_comb begin
        w_exc_mask = '0;
        for (int j = 0; j < int'(STAGES); j++) begin
            w_exc_mask[j] = (IdxW'(j) <= w_exc_idx);
        end
    end

    // Load-use compare across all consumer operands; x0 is never a real dependency.
    always_comb begin
        w_reg_hit = 1'b0;
        for (int k = 0; k < int'(HAZARD_REGS); k++) begin
            if ((useRegs[k*5 +: 5] != 5'd0) && (useRegs[k*5 +: 5] == loadRd)) begin
                w_reg_hit = 1'b1;
            end
        end
        w_hazard = useValid && loadValid && w_reg_hit;
    end

    // Next-state and output decode; priority is reset, memBusy, trap, exception, branch, load-use.
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_latch      = 1'b0;
        stall        = '0;
        flush        = '0;
        trapValid    = 1'b0;
        loadUseStall = 1'b0;

        if (!reset) begin
            // Outputs stay quiet; the register block performs the actual reset.
            w_state_next = StIdle;
            w_count_next = '0;
        end else if (memBusy) begin
            // Freeze everything; no events are evaluated while memory is busy.
            stall = '1;
        end else begin
            unique case (r_state)
                StTrap: begin
                    trapValid    = 1'b1;
                    flush        = '1;
                    w_state_next = StIdle;
                end
                StIdle: begin
                    if (w_exc_any) begin
                        flush        = w_exc_mask;
                        w_latch      = 1'b1;
                        w_state_next = StTrap;
                        w_count_next = '0;
                    end else if (branchValid) begin
                        flush[1:0]   = 2'b11;
                        w_count_next = '0;
                    end else if ((r_count != '0) || w_hazard) begin
                        stall[1:0]   = 2'b11;
                        flush[2]     = 1'b1;
                        loadUseStall = 1'b1;
                        w_count_next = (r_count != '0) ? (r_count - CntW'(1)) : CntReload;
                    end
                end
                default: begin
                    w_state_next = StIdle;
                end
            endcase
        end
    end

    // State, bubble counter and trap record registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= StIdle;
            r_count      <= '0;
            r_trap_cause <= '0;
            r_trap_pc    <= '0;
            r_trap_tval  <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            if (w_latch) begin
                r_trap_cause <= w_sel_cause;
                r_trap_pc    <= w_sel_pc;
                r_trap_tval  <= w_sel_tval;
            end
        end
    end

    assign trapCause = r_trap_cause;
    assign trapPc    = r_trap_pc;
    assign trapTval  = r_trap_tval;

endmodule

// File: tb/tb_trap_hazard_controller.sv
// Directed self-checking bench for trap_hazard_controller (STAGES=4, LOAD_USE_CYCLES=3).
module tb_trap_hazard_controller;

    localparam int unsigned STAGES  = 4;
    localparam int unsigned XLEN    = 32;
    localparam int unsigned CAUSE_W = 4;
    localparam int unsigned LUC     = 3;
    localparam int unsigned HREGS   = 2;

    logic                      clock = 1'b0;
    logic                      reset;
    logic [STAGES-1:0]         excValid;
    logic [STAGES*CAUSE_W-1:0] excCause;
    logic [STAGES*XLEN-1:0]    excPc;
    logic [STAGES*XLEN-1:0]    excTval;
    logic                      branchValid;
    logic                      memBusy;
    logic                      useValid;
    logic [HREGS*5-1:0]        useRegs;
    logic                      loadValid;
    logic [4:0]                loadRd;
    logic [STAGES-1:0]         stall;
    logic [STAGES-1:0]         flush;
    logic                      trapValid;
    logic [CAUSE_W-1:0]        trapCause;
    logic [XLEN-1:0]           trapPc;
    logic [XLEN-1:0]           trapTval;
    logic                      loadUseStall;

    int checks = 0;
    int errors = 0;

    trap_hazard_controller #(
        .STAGES          (STAGES),
        .XLEN            (XLEN),
        .CAUSE_W         (CAUSE_W),
        .LOAD_USE_CYCLES (LUC),
        .HAZARD_REGS     (HREGS)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .excValid     (excValid),
        .excCause     (excCause),
        .excPc        (excPc),
        .excTval      (excTval),
        .branchValid  (branchValid),
        .memBusy      (memBusy),
        .useValid     (useValid),
        .useRegs      (useRegs),
        .loadValid    (loadValid),
        .loadRd       (loadRd),
        .stall        (stall),
        .flush        (flush),
        .trapValid    (trapValid),
        .trapCause    (trapCause),
        .trapPc       (trapPc),
        .trapTval     (trapTval),
        .loadUseStall (loadUseStall)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then settle away from it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        excValid    = '0;
        excCause    = '0;
        excPc       = '0;
        excTval     = '0;
        branchValid = 1'b0;
        memBusy     = 1'b0;
        useValid    = 1'b0;
        useRegs     = '0;
        loadValid   = 1'b0;
        loadRd      = '0;
    endtask

    initial begin
        clear_inputs();
        reset    = 1'b0;
        excValid = 4'b1111;

        // Reset held three cycles with every stage excepting.
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("rst_stall", stall, 4'b0000);
            chk("rst_flush", flush, 4'b0000);
            chk("rst_trapValid", trapValid, 1'b0);
            tick();
        end
        reset = 1'b1;
        clear_inputs();
        #1;
        chk("rst_trapCause", trapCause, 4'h0);
        chk("rst_trapPc", trapPc, 32'h0);
        chk("rst_trapTval", trapTval, 32'h0);
        chk("rst_trapValid_after", trapValid, 1'b0);
        chk("rst_lus", loadUseStall, 1'b0);

        // Two excepting stages: stage 2 is the oldest and wins.
        excValid = 4'b0101;
        excCause = 16'h0B02;
        excPc    = {32'h0, 32'h0000_0100, 32'h0, 32'h0000_0044};
        excTval  = {32'h0, 32'h0000_DEAD, 32'h0, 32'h0000_0055};
        #1;
        chk("exc_flush", flush, 4'b0111);
        chk("exc_stall", stall, 4'b0000);
        chk("exc_trapValid_early", trapValid, 1'b0);
        tick();
        clear_inputs();
        #1;
        chk("trap_valid", trapValid, 1'b1);
        chk("trap_flush", flush, 4'b1111);
        chk("trap_cause", trapCause, 4'hB);
        chk("trap_pc", trapPc, 32'h100);
        chk("trap_tval", trapTval, 32'hDEAD);
        tick();
        chk("trap_pulse_end", trapValid, 1'b0);
        chk("trap_flush_end", flush, 4'b0000);
        chk("trap_cause_hold", trapCause, 4'hB);

        // Load-use on operand 0, three bubbles, with a memBusy cycle in the middle.
        useValid  = 1'b1;
        loadValid = 1'b1;
        loadRd    = 5'd5;
        useRegs   = {5'd0, 5'd5};
        #1;
        chk("lu_detect", loadUseStall, 1'b1);
        chk("lu_stall", stall, 4'b0011);
        chk("lu_flush", flush, 4'b0100);
        tick();
        useValid  = 1'b0;
        loadValid = 1'b0;
        #1;
        chk("lu_bubble2", loadUseStall, 1'b1);
        memBusy = 1'b1;
        #1;
        chk("lu_busy_stall", stall, 4'b1111);
        chk("lu_busy_flush", flush, 4'b0000);
        chk("lu_busy_lus", loadUseStall, 1'b0);
        tick();
        memBusy = 1'b0;
        #1;
        chk("lu_bubble2_held", loadUseStall, 1'b1);
        chk("lu_bubble2_stall", stall, 4'b0011);
        tick();
        chk("lu_bubble3", loadUseStall, 1'b1);
        chk("lu_bubble3_flush", flush, 4'b0100);
        tick();
        chk("lu_done", loadUseStall, 1'b0);
        chk("lu_done_stall", stall, 4'b0000);

        // x0 never creates a hazard.
        useValid  = 1'b1;
        loadValid = 1'b1;
        loadRd    = 5'd0;
        useRegs   = {5'd0, 5'd0};
        #1;
        chk("x0_lus", loadUseStall, 1'b0);
        chk("x0_stall", stall, 4'b0000);

        // Branch overrides a load-use hazard on operand 1.
        loadRd      = 5'd5;
        useRegs     = {5'd5, 5'd3};
        branchValid = 1'b1;
        #1;
        chk("br_flush", flush, 4'b0011);
        chk("br_stall", stall, 4'b0000);
        chk("br_lus", loadUseStall, 1'b0);
        tick();
        clear_inputs();
        #1;
        chk("br_no_bubble", loadUseStall, 1'b0);

        // Operand-1 hazard alone, then let the counter drain.
        useValid  = 1'b1;
        loadValid = 1'b1;
        loadRd    = 5'd9;
        useRegs   = {5'd9, 5'd3};
        #1;
        chk("lu1_detect", loadUseStall, 1'b1);
        tick();
        clear_inputs();
        tick();
        tick();
        chk("lu1_drained", loadUseStall, 1'b0);

        // Oldest-stage exception held off by memBusy for four cycles.
        excValid = 4'b1000;
        excCause = 16'h7000;
        excPc    = {32'h0000_0200, 96'h0};
        excTval  = {32'h0000_0033, 96'h0};
        memBusy  = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("busy_stall", stall, 4'b1111);
            chk("busy_flush", flush, 4'b0000);
            chk("busy_trapValid", trapValid, 1'b0);
            tick();
        end
        chk("busy_cause_hold", trapCause, 4'hB);
        memBusy = 1'b0;
        #1;
        chk("busy_rel_flush", flush, 4'b1111);
        chk("busy_rel_stall", stall, 4'b0000);
        tick();
        clear_inputs();
        #1;
        chk("busy_trap_valid", trapValid, 1'b1);
        chk("busy_trap_cause", trapCause, 4'h7);
        chk("busy_trap_pc", trapPc, 32'h200);
        chk("busy_trap_tval", trapTval, 32'h33);
        tick();
        chk("busy_trap_end", trapValid, 1'b0);

        // Reset asserted during the TRAP cycle abandons the pulse.
        excValid = 4'b0010;
        excCause = 16'h0050;
        excPc    = {64'h0, 32'h0000_0300, 32'h0};
        #1;
        chk("rt_flush", flush, 4'b0011);
        tick();
        clear_inputs();
        reset = 1'b0;
        #1;
        chk("rt_no_pulse", trapValid, 1'b0);
        chk("rt_flush_zero", flush, 4'b0000);
        tick();
        reset = 1'b1;
        #1;
        chk("rt_trapValid", trapValid, 1'b0);
        chk("rt_cause", trapCause, 4'h0);
        chk("rt_pc", trapPc, 32'h0);
        tick();
        chk("rt_still_quiet", trapValid, 1'b0);
        branchValid = 1'b1;
        #1;
        chk("rt_idle_branch", flush, 4'b0011);
        tick();
        clear_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
